// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with sequenced bulk clear
// Optional write-to-read bypass is enabled by defining REGFILE_BYPASS_EN.
module reg_file_param #(
    parameter int WIDTH     = 16,
    parameter int ADDR_W    = 4,
    parameter int ZERO_REG0 = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [WIDTH-1:0]  rd_data1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [WIDTH-1:0]  rd_data2,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic              wr_fire;
    logic              wr_keep;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    ptr_d   = '0;
                end
            end
            S_CLEAR: begin
                ptr_d = ptr_q + 1'b1;
                if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_ready = 1'b0;
        busy     = 1'b0;
        clr_done = 1'b0;
        case (state_q)
            S_IDLE:  wr_ready = 1'b1;
            S_CLEAR: busy     = 1'b1;
            S_DONE: begin
                busy     = 1'b1;
                clr_done = 1'b1;
            end
            default: wr_ready = 1'b0;
        endcase
    end

    assign wr_fire = wr_en && wr_ready;
    // Writes to a hardwired-zero entry 0 are accepted but never stored.
    assign wr_keep = !((ZERO_REG0 != 0) && (wr_addr == '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (state_q == S_CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else if (wr_fire && wr_keep) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [WIDTH-1:0] v;
        v = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_fire && (wr_addr == addr)) begin
            v = wr_data;
        end
`else
`endif
        if ((ZERO_REG0 != 0) && (addr == '0)) begin
            v = '0;
        end
        return v;
    endfunction

    always_comb begin
        rd_data1 = read_port(rd_addr1);
    end

    always_comb begin
        rd_data2 = read_port(rd_addr2);
    end

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - scoreboard bench for reg_file_param
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic [3:0]  rd_addr1 = '0;
    logic [3:0]  rd_addr2 = '0;
    logic        clr_req = 1'b0;
    logic        wr_ready, busy, clr_done;
    logic [15:0] rd_data1, rd_data2;
    logic        z_wr_ready, z_busy, z_clr_done;
    logic [15:0] z_rd_data1, z_rd_data2;

    always #5 clk = ~clk;

    reg_file_param #(.WIDTH(16), .ADDR_W(4), .ZERO_REG0(0)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .rd_addr1(rd_addr1), .rd_data1(rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(rd_data2), .clr_req(clr_req),
        .busy(busy), .clr_done(clr_done)
    );

    reg_file_param #(.WIDTH(16), .ADDR_W(4), .ZERO_REG0(1)) dut_z (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(z_wr_ready), .rd_addr1(rd_addr1), .rd_data1(z_rd_data1),
        .rd_addr2(rd_addr2), .rd_data2(z_rd_data2), .clr_req(clr_req),
        .busy(z_busy), .clr_done(z_clr_done)
    );

    localparam int K_RD1 = 0, K_RD2 = 1, K_BUSY = 2, K_WRDY = 3, K_DONE = 4,
                   K_ZRD1 = 5, K_ZRD2 = 6;

    typedef struct {
        int          cyc;
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_val(input int kind, input logic [15:0] exp, input string name);
        exp_t e;
        e.cyc  = cyc;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t        e;
            logic [15:0] act;
            e = sb.pop_front();
            case (e.kind)
                K_RD1:   act = rd_data1;
                K_RD2:   act = rd_data2;
                K_BUSY:  act = {15'd0, busy};
                K_WRDY:  act = {15'd0, wr_ready};
                K_DONE:  act = {15'd0, clr_done};
                K_ZRD1:  act = z_rd_data1;
                default: act = z_rd_data2;
            endcase
            n_checks++;
            if (e.cyc != cyc) begin
                $display("FAIL %s: stale expectation from cycle %0d seen at cycle %0d", e.name, e.cyc, cyc);
            end else if (act !== e.exp) begin
                $display("FAIL %s (cycle %0d): got 0x%04h expected 0x%04h", e.name, cyc, act, e.exp);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic fill_all(input logic [15:0] v);
        for (int a = 0; a < 16; a++) begin
            wr_en   = 1'b1;
            wr_addr = 4'(a);
            wr_data = v;
            step();
        end
        wr_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        step();
        rst = 1'b0;
        expect_val(K_BUSY, 16'd0, "reset_busy");
        expect_val(K_WRDY, 16'd1, "reset_wr_ready");
        expect_val(K_DONE, 16'd0, "reset_clr_done");
        for (int a = 0; a < 16; a++) begin
            rd_addr1 = 4'(a);
            rd_addr2 = 4'(15 - a);
            expect_val(K_RD1, 16'h0000, "reset_rd1");
            expect_val(K_RD2, 16'h0000, "reset_rd2");
            step();
        end

        // Write then read
        wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF;
        rd_addr1 = 4'd4; rd_addr2 = 4'd4;
        expect_val(K_RD1, 16'h0000, "wr_cycle_addr4_rd1");
        step();
        wr_en = 1'b0;
        rd_addr1 = 4'd5; rd_addr2 = 4'd5;
        expect_val(K_RD1, 16'hBEEF, "wr_then_rd1");
        expect_val(K_RD2, 16'hBEEF, "wr_then_rd2");
        step();
        rd_addr1 = 4'd4;
        expect_val(K_RD1, 16'h0000, "addr4_untouched");
        step();

        // Bypass
        wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'h1234;
        rd_addr1 = 4'd3; rd_addr2 = 4'd5;
`ifdef REGFILE_BYPASS_EN
        expect_val(K_RD1, 16'h1234, "bypass_same_cycle");
`else
        expect_val(K_RD1, 16'h0000, "no_bypass_same_cycle");
`endif
        expect_val(K_RD2, 16'hBEEF, "bypass_other_port");
        step();
        wr_en = 1'b0;
        expect_val(K_RD1, 16'h1234, "bypass_next_cycle");
        step();

        // Clear sequence with dropped writes
        fill_all(16'hA5A5);
        rd_addr1 = 4'd9;
        expect_val(K_RD1, 16'hA5A5, "fill_readback");
        clr_req = 1'b1;
        expect_val(K_BUSY, 16'd0, "clr_req_cycle_busy");
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'h1111;
            rd_addr1 = 4'((i == 0) ? 0 : i - 1);
            rd_addr2 = 4'(i);
            expect_val(K_BUSY, 16'd1, "clear_busy");
            expect_val(K_WRDY, 16'd0, "clear_wr_ready");
            expect_val(K_DONE, 16'd0, "clear_no_done");
            if (i > 0) expect_val(K_RD1, 16'h0000, "clear_below_ptr");
            expect_val(K_RD2, 16'hA5A5, "clear_at_ptr");
            step();
        end
        rd_addr1 = 4'd0;
        expect_val(K_BUSY, 16'd1, "done_busy");
        expect_val(K_DONE, 16'd1, "done_pulse");
        expect_val(K_WRDY, 16'd0, "done_wr_ready");
        expect_val(K_RD1, 16'h0000, "done_no_bypass");
        step();
        wr_en = 1'b0;
        expect_val(K_BUSY, 16'd0, "post_clear_busy");
        expect_val(K_DONE, 16'd0, "post_clear_done_low");
        expect_val(K_WRDY, 16'd1, "post_clear_wr_ready");
        for (int a = 0; a < 16; a += 2) begin
            rd_addr1 = 4'(a);
            rd_addr2 = 4'(a + 1);
            expect_val(K_RD1, 16'h0000, "post_clear_rd1");
            expect_val(K_RD2, 16'h0000, "post_clear_rd2");
            step();
        end

        // Reset mid-clear
        fill_all(16'hA5A5);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        expect_val(K_BUSY, 16'd1, "pre_reset_busy");
        step();
        rst = 1'b0;
        expect_val(K_BUSY, 16'd0, "mid_reset_busy");
        expect_val(K_WRDY, 16'd1, "mid_reset_wr_ready");
        for (int i = 0; i < 16; i++) begin
            rd_addr1 = 4'(i);
            rd_addr2 = 4'(15 - i);
            expect_val(K_RD1, 16'h0000, "mid_reset_rd1");
            expect_val(K_RD2, 16'h0000, "mid_reset_rd2");
            expect_val(K_DONE, 16'd0, "mid_reset_no_done");
            step();
        end

        // Hardwired zero entry
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
        rd_addr1 = 4'd0; rd_addr2 = 4'd1;
        expect_val(K_ZRD1, 16'h0000, "zero_reg_same_cycle");
`ifdef REGFILE_BYPASS_EN
        expect_val(K_RD1, 16'hFFFF, "plain_addr0_bypass");
`else
        expect_val(K_RD1, 16'h0000, "plain_addr0_old");
`endif
        step();
        wr_addr = 4'd1; wr_data = 16'h5A5A;
        expect_val(K_ZRD1, 16'h0000, "zero_reg_after_write");
        expect_val(K_RD1, 16'hFFFF, "plain_addr0_written");
        step();
        wr_en = 1'b0;
        rd_addr1 = 4'd1; rd_addr2 = 4'd0;
        expect_val(K_ZRD1, 16'h5A5A, "zero_cfg_addr1");
        expect_val(K_ZRD2, 16'h0000, "zero_cfg_port2_addr0");
        step();

        for (int i = 0; i < 4 && sb.size() > 0; i++) step();
        if (sb.size() > 0) begin
            n_checks += sb.size();
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
